// File: rtl/dshot_frame_scheduler.sv
// Periodic Wishbone master that refreshes a 4-channel DSHOT controller: one STATUS poll, then MOTOR1..4 writes.
// One transfer in flight, held until ack or ACK_TIMEOUT clocks, with at least one idle cycle between transfers.
module dshot_frame_scheduler #(
    parameter logic [31:0] DSHOT_BASE     = 32'h0,
    parameter int          REFRESH_CYCLES = 72000,
    parameter int          FAILSAFE_TICKS = 100,
    parameter int          ACK_TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        enable_i,
    input  logic        throttle_valid_i,
    input  logic [10:0] throttle0_i,
    input  logic [10:0] throttle1_i,
    input  logic [10:0] throttle2_i,
    input  logic [10:0] throttle3_i,
    input  logic [3:0]  telem_req_i,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    output logic        m_wb_we_o,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i,
    output logic        frame_done_o,
    output logic        failsafe_o,
    output logic [7:0]  skip_cnt_o,
    output logic        bus_err_o
);

    localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int FW = $clog2(FAILSAFE_TICKS + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_GAP,
        S_WR,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [FW-1:0] fs_cnt;
    logic          failsafe_q;
    logic [10:0]   thr_hold [4];
    logic [3:0]    tel_hold;
    logic [15:0]   frame_q  [4];
    logic [1:0]    widx;
    logic [AW-1:0] wait_cnt;
    logic [7:0]    skip_cnt_q;
    logic          bus_err_q;

    logic          bus_busy;
    logic          ack_timeout;
    logic          status_ready;
    logic          tick_drop;
    logic          status_bad;
    logic [1:0]    skip_inc;
    logic [8:0]    skip_sum;
    logic          unused_status_hi;

    function automatic logic [15:0] build_frame(input logic [10:0] thr, input logic tel,
                                                input logic zero);
        logic [11:0] v;
        v = zero ? 12'h000 : {thr, tel};
        return {v, v[3:0] ^ v[7:4] ^ v[11:8]};
    endfunction

    assign unused_status_hi = ^m_wb_dat_i[31:4];

    assign tick         = enable_i && (tick_cnt == TW'(REFRESH_CYCLES - 1));
    assign bus_busy     = (state == S_POLL) || (state == S_WR);
    assign ack_timeout  = bus_busy && !m_wb_ack_i && (wait_cnt == AW'(ACK_TIMEOUT - 1));
    assign status_ready = (m_wb_dat_i[3:0] == 4'hF);
    assign tick_drop    = tick && (state != S_IDLE);
    assign status_bad   = (state == S_POLL) && m_wb_ack_i && !status_ready;
    assign skip_inc     = {1'b0, tick_drop} + {1'b0, status_bad};
    assign skip_sum     = {1'b0, skip_cnt_q} + {7'b0, skip_inc};

    assign failsafe_o   = failsafe_q;
    assign skip_cnt_o   = skip_cnt_q;
    assign bus_err_o    = bus_err_q;
    assign m_wb_sel_o   = 4'hF;

    // Refresh tick generator: free-runs only while enabled.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !enable_i || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Throttle hold registers and failsafe watchdog.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int n = 0; n < 4; n++) begin
                thr_hold[n] <= '0;
            end
            tel_hold   <= '0;
            fs_cnt     <= '0;
            failsafe_q <= 1'b1;
        end else if (throttle_valid_i) begin
            thr_hold[0] <= throttle0_i;
            thr_hold[1] <= throttle1_i;
            thr_hold[2] <= throttle2_i;
            thr_hold[3] <= throttle3_i;
            tel_hold    <= telem_req_i;
            fs_cnt      <= '0;
            failsafe_q  <= 1'b0;
        end else if (tick) begin
            if (fs_cnt != FW'(FAILSAFE_TICKS)) begin
                fs_cnt <= fs_cnt + 1'b1;
            end
            if (fs_cnt >= FW'(FAILSAFE_TICKS - 1)) begin
                failsafe_q <= 1'b1;
            end
        end
    end

    // Frame snapshot, transfer sequencing and status counters.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int n = 0; n < 4; n++) begin
                frame_q[n] <= '0;
            end
            widx       <= '0;
            wait_cnt   <= '0;
            skip_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && tick) begin
                for (int n = 0; n < 4; n++) begin
                    frame_q[n] <= build_frame(thr_hold[n], tel_hold[n], failsafe_q);
                end
                widx <= '0;
            end else if (state == S_WR && m_wb_ack_i) begin
                widx <= widx + 1'b1;
            end

            if (bus_busy && !m_wb_ack_i) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            skip_cnt_q <= skip_sum[8] ? 8'hFF : skip_sum[7:0];

            if (ack_timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_nxt = S_POLL;
                end
            end
            S_POLL: begin
                if (m_wb_ack_i) begin
                    state_nxt = status_ready ? S_GAP : S_IDLE;
                end else if (ack_timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                state_nxt = S_WR;
            end
            S_WR: begin
                if (m_wb_ack_i) begin
                    state_nxt = (widx == 2'd3) ? S_DONE : S_GAP;
                end else if (ack_timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus signals decode straight from registered state, so they stay stable for the whole transfer.
    always_comb begin
        m_wb_cyc_o   = 1'b0;
        m_wb_stb_o   = 1'b0;
        m_wb_we_o    = 1'b0;
        m_wb_adr_o   = '0;
        m_wb_dat_o   = '0;
        frame_done_o = 1'b0;
        case (state)
            S_POLL: begin
                m_wb_cyc_o = 1'b1;
                m_wb_stb_o = 1'b1;
                m_wb_adr_o = DSHOT_BASE + 32'h10;
            end
            S_WR: begin
                m_wb_cyc_o = 1'b1;
                m_wb_stb_o = 1'b1;
                m_wb_we_o  = 1'b1;
                m_wb_adr_o = DSHOT_BASE + {28'h0, widx, 2'b00};
                m_wb_dat_o = {16'h0, frame_q[widx]};
            end
            S_DONE: begin
                frame_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dshot_frame_scheduler.sv
// Directed bench for dshot_frame_scheduler: frame table, status skip, ack timeout, failsafe, slow slave, reset abort.
module tb_dshot_frame_scheduler;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int RC = 64;
    localparam int FT = 3;
    localparam int AT = 100;
    localparam int NEVER = 1000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic [10:0] thr0 = '0, thr1 = '0, thr2 = '0, thr3 = '0;
    logic [3:0]  tel = '0;
    logic [31:0] adr, dat_o;
    logic [31:0] rdat = 32'h0000_000F;
    logic        we, cyc, stb, done, fs, berr;
    logic        ack = 1'b0;
    logic [3:0]  sel;
    logic [7:0]  skip;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } txn_t;

    typedef struct packed {
        logic [3:0][10:0] thr;
        logic [3:0]       tel;
        logic [3:0][15:0] exp;
    } vec_t;

    txn_t log_q[$];
    vec_t vecs [3];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   poll_delay = 0;
    int   wr_delay = 0;

    always #5 clk = ~clk;

    dshot_frame_scheduler #(
        .DSHOT_BASE    (BASE),
        .REFRESH_CYCLES(RC),
        .FAILSAFE_TICKS(FT),
        .ACK_TIMEOUT   (AT)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .enable_i        (enable),
        .throttle_valid_i(valid),
        .throttle0_i     (thr0),
        .throttle1_i     (thr1),
        .throttle2_i     (thr2),
        .throttle3_i     (thr3),
        .telem_req_i     (tel),
        .m_wb_adr_o      (adr),
        .m_wb_dat_o      (dat_o),
        .m_wb_we_o       (we),
        .m_wb_sel_o      (sel),
        .m_wb_cyc_o      (cyc),
        .m_wb_stb_o      (stb),
        .m_wb_dat_i      (rdat),
        .m_wb_ack_i      (ack),
        .frame_done_o    (done),
        .failsafe_o      (fs),
        .skip_cnt_o      (skip),
        .bus_err_o       (berr)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_valid(input logic [3:0][10:0] t, input logic [3:0] te);
        thr0  = t[0];
        thr1  = t[1];
        thr2  = t[2];
        thr3  = t[3];
        tel   = te;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int budget);
        int  start;
        bit  ok;
        start = done_cnt;
        ok    = 1'b0;
        log_q.delete();
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " frame_done seen"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic check_writes(input string tag, input logic [3:0][15:0] exp);
        check({tag, " txn count"}, log_q.size(), 32'd5);
        if (log_q.size() == 5) begin
            check({tag, " poll adr"}, log_q[0].adr, BASE + 32'h10);
            check({tag, " poll we"}, {31'b0, log_q[0].we}, 32'd0);
            for (int n = 0; n < 4; n++) begin
                check($sformatf("%s wr%0d adr", tag, n), log_q[n+1].adr, BASE + 32'(4 * n));
                check($sformatf("%s wr%0d we", tag, n), {31'b0, log_q[n+1].we}, 32'd1);
                check($sformatf("%s wr%0d dat", tag, n), log_q[n+1].dat, {16'h0, exp[n]});
            end
        end
    endtask

    // Wishbone slave model with programmable ack latency, transaction log and frame_done counter.
    initial begin
        int wait_n;
        int lim;
        wait_n = 0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (ack) begin
                ack = 1'b0;
                check("idle cycle after ack", {31'b0, cyc}, 32'd0);
            end else if (cyc && stb) begin
                lim = we ? wr_delay : poll_delay;
                if (wait_n >= lim) begin
                    ack = 1'b1;
                    log_q.push_back('{adr, dat_o, we});
                    wait_n = 0;
                end else begin
                    wait_n++;
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  skip0;
        int  done0;
        int  n_high;
        bit  found;
        logic [3:0][10:0] thr_max;
        logic [3:0][15:0] all_ff;

        vecs[0].thr = {11'd2047, 11'd0, 11'd48, 11'd1046};
        vecs[0].tel = 4'b1010;
        vecs[0].exp = {16'hFFFF, 16'h0000, 16'h0617, 16'h82C6};
        vecs[1].thr = {11'd291, 11'd1365, 11'd1024, 11'd1};
        vecs[1].tel = 4'b1001;
        vecs[1].exp = {16'h2471, 16'hAAAA, 16'h8008, 16'h0033};
        vecs[2].thr = {11'd7, 11'd1500, 11'd100, 11'd2047};
        vecs[2].tel = 4'b1010;
        vecs[2].exp = {16'h00FF, 16'hBB88, 16'h0C95, 16'hFFEE};
        thr_max = {4{11'd2047}};
        all_ff  = {4{16'hFFFF}};

        rst = 1'b1;
        repeat (3) step();
        check("reset cyc", {31'b0, cyc}, 32'd0);
        check("reset stb", {31'b0, stb}, 32'd0);
        check("reset we", {31'b0, we}, 32'd0);
        check("reset adr", adr, 32'd0);
        check("reset dat", dat_o, 32'd0);
        check("reset frame_done", {31'b0, done}, 32'd0);
        check("reset failsafe", {31'b0, fs}, 32'd1);
        check("reset skip", {24'b0, skip}, 32'd0);
        check("reset bus_err", {31'b0, berr}, 32'd0);
        rst = 1'b0;
        step();

        // Frame table: each vector refreshed once with its own snapshot.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse_valid(vecs[i].thr, vecs[i].tel);
            check($sformatf("v%0d failsafe cleared", i), {31'b0, fs}, 32'd0);
            run_frame($sformatf("v%0d", i), 300);
            check_writes($sformatf("v%0d", i), vecs[i].exp);
        end

        // Controller not ready: poll only, tick counted as skipped.
        done0 = done_cnt;
        rdat  = 32'h0000_0007;
        log_q.delete();
        for (int i = 0; i < 200 && log_q.size() == 0; i++) step();
        repeat (20) step();
        check("not-ready txn count", log_q.size(), 32'd1);
        check("not-ready skip", {24'b0, skip}, 32'd1);
        check("not-ready no frame_done", done_cnt, done0);
        rdat = 32'h0000_000F;

        // Ack never arrives: cyc held exactly AT clocks, then bus error.
        check("bus_err before timeout", {31'b0, berr}, 32'd0);
        poll_delay = NEVER;
        done0 = done_cnt;
        for (int i = 0; i < 200 && !cyc; i++) step();
        n_high = 0;
        do begin
            n_high++;
            step();
        end while (cyc && n_high < 300);
        check("timeout cyc high clocks", n_high, AT);
        check("timeout bus_err", {31'b0, berr}, 32'd1);
        check("timeout no frame_done", done_cnt, done0);
        poll_delay = 0;

        // Failsafe: no valid after this one, forced zero after the 3rd tick.
        pulse_valid(thr_max, 4'hF);
        run_frame("fs1", 300);
        check_writes("fs1", all_ff);
        check("fs1 failsafe", {31'b0, fs}, 32'd0);
        run_frame("fs2", 300);
        check("fs2 failsafe", {31'b0, fs}, 32'd0);
        run_frame("fs3", 300);
        check("fs3 failsafe", {31'b0, fs}, 32'd1);
        check_writes("fs3", all_ff);
        run_frame("fs4", 300);
        check_writes("fs4", '0);
        pulse_valid(vecs[0].thr, vecs[0].tel);
        check("failsafe cleared by valid", {31'b0, fs}, 32'd0);

        // Slow STATUS ack overlaps the next tick: one tick dropped, frame still complete.
        skip0 = skip;
        poll_delay = 70;
        run_frame("slow", 500);
        check("slow skip inc", {24'b0, skip}, 32'(skip0 + 1));
        check_writes("slow", vecs[0].exp);
        poll_delay = 0;

        // Reset while WR2 waits for ack.
        wr_delay = 30;
        log_q.delete();
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (log_q.size() == 3 && cyc && adr == BASE + 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        check("reached WR2 wait", {31'b0, found}, 32'd1);
        rst = 1'b1;
        step();
        check("abort cyc", {31'b0, cyc}, 32'd0);
        check("abort stb", {31'b0, stb}, 32'd0);
        check("abort we", {31'b0, we}, 32'd0);
        check("abort adr", adr, 32'd0);
        check("abort dat", dat_o, 32'd0);
        check("abort frame_done", {31'b0, done}, 32'd0);
        check("abort failsafe", {31'b0, fs}, 32'd1);
        check("abort skip", {24'b0, skip}, 32'd0);
        check("abort bus_err", {31'b0, berr}, 32'd0);
        rst = 1'b0;
        wr_delay = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
